// File: rtl/life_row_stepper.sv
// Streaming Game-of-Life stepper: each output row is loaded on the edge that accepts the next input row (or in FLUSH for the last row).
// A single-entry output register; input stalls while that slot is occupied and not draining, and for one FLUSH cycle per frame.
`timescale 1ns/1ps
module life_row_stepper #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic             out_last
);

    typedef enum logic [1:0] {
        EMPTY,
        PRIMED,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] center;
    logic [WIDTH-1:0] above_next;
    logic [WIDTH-1:0] center_next;
    logic [WIDTH-1:0] below;
    logic [WIDTH-1:0] gen_row;
    logic             free;
    logic             in_fire;
    logic             load;
    logic             load_last;

    assign free     = !out_valid || out_ready;
    assign in_ready = (state != FLUSH) && free;
    assign in_fire  = in_valid && in_ready;

    // The row below the last row of a frame is all-zero.
    assign below = (state == FLUSH) ? '0 : in_row;

    // Zero-padded copies give the dead border: column j lives at pad index j+1.
    logic [WIDTH+1:0] a_pad;
    logic [WIDTH+1:0] c_pad;
    logic [WIDTH+1:0] b_pad;

    assign a_pad = {1'b0, above, 1'b0};
    assign c_pad = {1'b0, center, 1'b0};
    assign b_pad = {1'b0, below, 1'b0};

    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        logic [1:0] p0;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] p3;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [3:0] n;

        assign p0 = {1'b0, a_pad[j]}   + {1'b0, a_pad[j+1]};
        assign p1 = {1'b0, a_pad[j+2]} + {1'b0, c_pad[j]};
        assign p2 = {1'b0, c_pad[j+2]} + {1'b0, b_pad[j]};
        assign p3 = {1'b0, b_pad[j+1]} + {1'b0, b_pad[j+2]};
        assign s0 = {1'b0, p0} + {1'b0, p1};
        assign s1 = {1'b0, p2} + {1'b0, p3};
        assign n  = {1'b0, s0} + {1'b0, s1};

        assign gen_row[j] = (n == 4'd3) || (c_pad[j+1] && (n == 4'd2));
    end

    always_comb begin
        state_next  = state;
        above_next  = above;
        center_next = center;
        load        = 1'b0;
        load_last   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    above_next  = '0;
                    center_next = in_row;
                    state_next  = in_last ? FLUSH : PRIMED;
                end
            end
            PRIMED: begin
                if (in_fire) begin
                    load        = 1'b1;
                    above_next  = center;
                    center_next = in_row;
                    state_next  = in_last ? FLUSH : PRIMED;
                end
            end
            FLUSH: begin
                if (free) begin
                    load        = 1'b1;
                    load_last   = 1'b1;
                    above_next  = '0;
                    center_next = '0;
                    state_next  = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            above  <= '0;
            center <= '0;
        end else begin
            state  <= state_next;
            above  <= above_next;
            center <= center_next;
        end
    end

    // A fresh load replaces a row leaving in the same cycle, so no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_row   <= gen_row;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_row_stepper.sv
// Bench for life_row_stepper: table of rows with hand-derived next generations, scoreboard queue, corner sequences.
`timescale 1ns/1ps
module tb_life_row_stepper;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_row;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_row;
    logic         out_last;

    always #5 clk = ~clk;

    life_row_stepper #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_last (out_last)
    );

    typedef struct {
        logic [7:0] row;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] row;
        logic       last;
        logic [7:0] exp_row;
        logic       exp_last;
    } vec_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;

    // Reference neighbour count, written as a plain bounded scan.
    function automatic logic [7:0] model_next(input logic [7:0] a, input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        int         n;
        int         k;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                k = j + d;
                if (k >= 0 && k < 8) begin
                    n = n + int'(a[k]) + int'(b[k]);
                    if (d != 0) n = n + int'(c[k]);
                end
            end
            r[j] = (n == 3) || (c[j] && n == 2);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            n_out++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got row=%h last=%b want no output", out_row, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_row !== e.row || out_last !== e.last) begin
                    n_err++;
                    $display("FAIL out_row: got row=%h last=%b want row=%h last=%b",
                             out_row, out_last, e.row, e.last);
                end
            end
        end
    end

    task automatic drive_row(input logic [7:0] row, input logic last, input logic push,
                             input logic [7:0] er, input logic el, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        in_row   = row;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back('{row: er, last: el});
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles want 1 (row %h)", row);
        end
    endtask

    task automatic drive_vec(input int i, output int stalls);
        drive_row(vecs[i].row, vecs[i].last, 1'b1, vecs[i].exp_row, vecs[i].exp_last, stalls);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int c0;
        bit found;
        logic [7:0] rr[6];

        vecs[0] = '{8'h00, 1'b0, 8'h08, 1'b0};
        vecs[1] = '{8'h1C, 1'b0, 8'h08, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h08, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h18, 1'b0, 8'h18, 1'b0};
        vecs[5] = '{8'h18, 1'b0, 8'h18, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'hFF, 1'b1, 8'h7E, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_row", out_row, 0);
        check("reset_out_last", out_last, 0);
        check("reset_in_ready", in_ready, 1);
        reset = 1'b0;

        // Blinker, with first-output timing
        drive_vec(0, st);
        check("s1_no_out_after_row0", out_valid, 0);
        drive_vec(1, st);
        check("s1_out_valid_after_row1", out_valid, 1);
        check("s1_first_row", out_row, 8'h08);
        drive_vec(2, st);
        in_valid = 1'b0;
        check("s1_flush_in_ready", in_ready, 0);
        drain("s1_drain");

        // Single-row frame
        drive_vec(7, st);
        in_valid = 1'b0;
        check("s2_flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("s2_out_valid", out_valid, 1);
        check("s2_out_row", out_row, 8'h7E);
        check("s2_out_last", out_last, 1);
        drain("s2_drain");

        // Block still life
        for (int i = 3; i <= 6; i++) drive_vec(i, st);
        in_valid = 1'b0;
        drain("s3_drain");

        // Backpressure on the blinker
        fork
            begin
                int s4;
                for (int i = 0; i <= 2; i++) drive_vec(i, s4);
                in_valid = 1'b0;
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 50 && !found; t++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) found = 1'b1;
                end
                check("s4_first_valid_seen", found, 1);
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("s4_in_ready_held_low", in_ready, 0);
                    check("s4_out_valid_held", out_valid, 1);
                    check("s4_out_row_held", out_row, 8'h08);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("s4_drain");

        // Reset mid-frame discards held rows and the pending output
        out_ready = 1'b0;
        drive_row(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, st);
        drive_row(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, st);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("s5_out_valid", out_valid, 0);
        check("s5_in_ready", in_ready, 1);
        check("s5_out_row", out_row, 0);
        out_ready = 1'b1;
        for (int i = 0; i <= 2; i++) drive_vec(i, st);
        in_valid = 1'b0;
        drain("s5_drain");

        // Back-to-back frames with in_valid held high
        c0 = n_out;
        for (int i = 0; i <= 2; i++) drive_vec(i, st);
        drive_vec(3, st);
        check("s6_gap_cycles", st, 1);
        for (int i = 4; i <= 6; i++) drive_vec(i, st);
        in_valid = 1'b0;
        drain("s6_drain");
        check("s6_output_count", n_out - c0, 7);

        // Random frame checked against the reference model
        for (int k = 0; k < 6; k++) rr[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ab;
            logic [7:0] bl;
            ab = (k == 0) ? 8'h00 : rr[k-1];
            bl = (k == 5) ? 8'h00 : rr[k+1];
            drive_row(rr[k], k == 5, 1'b1, model_next(ab, rr[k], bl), k == 5, st);
        end
        in_valid = 1'b0;
        drain("s7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/life_row_stepper.md
Name: life_row_stepper

Overview:
- Streaming Game-of-Life generation engine.
- Accepts a frame as a sequence of WIDTH-bit rows, one per valid/ready beat.
- Buffers the two previous rows and computes each cell's 8-neighbour count.
- Emits the next-generation frame row by row, one row behind the input, through a single-entry output register with valid/ready.

Parameters:
WIDTH, 8, cells per row (>= 3); bit j of any row = column j.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
IN_VALID  input  1  IN_ROW/IN_LAST valid.
IN_READY  output  1  block accepts a row this cycle.
IN_ROW  input  WIDTH  current-generation row.
IN_LAST  input  1  marks the final row of the frame.
OUT_VALID  output  1  OUT_ROW/OUT_LAST valid.
OUT_READY  input  1  consumer accepts the output row.
OUT_ROW  output  WIDTH  next-generation row.
OUT_LAST  output  1  marks the final output row of the frame.

Behaviour:
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
- Internal registers:
  - ABOVE and CENTER (WIDTH bits each).
  - Output register: OUT_ROW, OUT_LAST, OUT_VALID.
- States: EMPTY, PRIMED, FLUSH.
- Reset values:
  - State = EMPTY; ABOVE = CENTER = 0.
  - OUT_VALID = 0, OUT_ROW = 0, OUT_LAST = 0.
  - Reset mid-frame discards all held rows and any pending output; no partial frame is emitted.
- Output slot free: free = !OUT_VALID || OUT_READY.
- IN_READY = (state != FLUSH) && free. IN_READY is combinational from OUT_READY and state.
- EMPTY, on input transfer:
  - CENTER <= IN_ROW; ABOVE <= 0; no output.
  - Next state is FLUSH if IN_LAST, else PRIMED.
- PRIMED, on input transfer:
  - Output register <= next(ABOVE, CENTER, IN_ROW); OUT_LAST <= 0; OUT_VALID <= 1.
  - ABOVE <= CENTER; CENTER <= IN_ROW.
  - Next state is FLUSH if IN_LAST, else PRIMED.
- FLUSH, when free:
  - Output register <= next(ABOVE, CENTER, 0); OUT_LAST <= 1; OUT_VALID <= 1.
  - ABOVE <= 0; CENTER <= 0; next state EMPTY.
  - FLUSH lasts at least one cycle, so IN_READY is low for at least one cycle between frames.
- When no new output is loaded: OUT_VALID clears on output transfer. OUT_ROW and OUT_LAST hold stable while OUT_VALID && !OUT_READY.
- next(a, c, b), per column j:
  - n = a[j-1] + a[j] + a[j+1] + c[j-1] + c[j+1] + b[j-1] + b[j] + b[j+1].
  - Indices outside 0..WIDTH-1 read 0: dead border, no wrap-around.
  - n is 4-bit unsigned, range 0..8, built from 2-bit-to-3-bit adder stages feeding a 4-bit sum.
  - Result[j] = (n == 3) || (c[j] && n == 2).
- Latency:
  - Output row k is loaded on the clock edge that accepts input row k+1.
  - The last output row is loaded on the first free cycle in FLUSH.
  - With OUT_READY held at 1, an R-row frame yields exactly R output rows.
- Frame boundaries: the row above the first row and the row below the last row are both treated as all-zero.
- Simultaneous events:
  - An output transfer and a new load in the same cycle is legal; the new row replaces the old with no bubble.
  - RESET overrides all handshakes.
- IN_VALID with IN_READY low: the input is ignored and no state changes.

Test Plan (WIDTH=8, OUT_READY=1 unless stated):
1. Blinker: rows 0x00, 0x1C, 0x00 (IN_LAST on the third), back-to-back -> outputs 0x08, 0x08, 0x08, OUT_LAST only on the third; first OUT_VALID the cycle after the second input transfer.
2. Single-row frame: 0xFF with IN_LAST=1 -> one output 0x7E with OUT_LAST=1 (edges die, interior survives with 2 neighbours); IN_READY low during the FLUSH cycle.
3. Block still life: 0x00, 0x18, 0x18, 0x00 -> outputs 0x00, 0x18, 0x18, 0x00; dead cells with n=1..2 stay dead.
4. Backpressure: replay the blinker with OUT_READY=0 for 5 cycles after the first OUT_VALID -> IN_READY=0 while pending, OUT_ROW holds 0x08, no row lost or duplicated after release; the sequence is identical to scenario 1.
5. Reset mid-frame: accept 0xFF, 0xFF, then RESET for 1 cycle -> OUT_VALID=0, IN_READY=1, OUT_ROW=0; the following blinker frame yields exactly 0x08, 0x08, 0x08 with no stale data.
6. Back-to-back frames: blinker, then the block frame with IN_VALID held high -> exactly one cycle of IN_READY=0 between frames; 7 outputs total, OUT_LAST on the 3rd and 7th.
